// File: rtl/dino_jump_ctrl.sv
// T-Rex vertical-motion controller: detects game ticks from the divider's level
// output and steps a ground/duck/rise/hang/fall state machine once per tick.
module dino_jump_ctrl #(
  parameter int Y_W        = 8,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_Y      = 120,
  parameter int HANG_TICKS = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick_in,
  input  logic           jump_btn,
  input  logic           duck_btn,
  input  logic           freeze,
  output logic [Y_W-1:0] dino_y,
  output logic [2:0]     dino_state,
  output logic           airborne,
  output logic           land_pulse
);

  typedef enum logic [2:0] {
    ST_GROUND = 3'd0,
    ST_DUCK   = 3'd1,
    ST_RISE   = 3'd2,
    ST_HANG   = 3'd3,
    ST_FALL   = 3'd4
  } state_t;

  localparam int HC_W = (HANG_TICKS < 2) ? 1 : $clog2(HANG_TICKS + 1);

  localparam logic [Y_W-1:0]  JUMP_V_L = Y_W'(JUMP_V);
  localparam logic [Y_W-1:0]  MAX_Y_L  = Y_W'(MAX_Y);
  localparam logic [Y_W-1:0]  GRAV_L   = Y_W'(GRAVITY);
  localparam logic [Y_W:0]    JUMP_V_X = {1'b0, JUMP_V_L};
  localparam logic [Y_W:0]    MAX_Y_X  = {1'b0, MAX_Y_L};
  localparam logic [HC_W-1:0] HANG_L   = HC_W'(HANG_TICKS);
  localparam logic [HC_W-1:0] HC_ONE   = HC_W'(1);

  state_t          state, state_next;
  logic [Y_W-1:0]  y, y_next;
  logic [Y_W-1:0]  vel, vel_next;
  logic [HC_W-1:0] hang_cnt, hang_next;
  logic            land_next;

  logic jump_s1, jump_s2, jump_prev;
  logic duck_s1, duck_s2;
  logic tick_d;
  logic jump_req;

  logic           jump_rise, tick_evt, step, in_air;
  logic [Y_W:0]   rise_sum, fall_sum;

  assign jump_rise = jump_s2 & ~jump_prev;
  assign tick_evt  = tick_in & ~tick_d;
  assign step      = tick_evt & ~freeze;
  assign in_air    = (state == ST_RISE) || (state == ST_HANG) || (state == ST_FALL);
  // Carry bit keeps the apex clamp correct when y+vel overflows Y_W.
  assign rise_sum  = {1'b0, y} + {1'b0, vel};
  assign fall_sum  = {1'b0, vel} + {1'b0, GRAV_L};

  // Button synchronisers, tick edge detector and the one-shot jump request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_s1   <= 1'b0;
      jump_s2   <= 1'b0;
      jump_prev <= 1'b0;
      duck_s1   <= 1'b0;
      duck_s2   <= 1'b0;
      tick_d    <= 1'b0;
      jump_req  <= 1'b0;
    end else begin
      jump_s1   <= jump_btn;
      jump_s2   <= jump_s1;
      jump_prev <= jump_s2;
      duck_s1   <= duck_btn;
      duck_s2   <= duck_s1;
      tick_d    <= tick_in;
      if (freeze || in_air) jump_req <= 1'b0;
      else if (jump_rise)   jump_req <= 1'b1;
      else if (tick_evt)    jump_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_GROUND;
      y          <= '0;
      vel        <= '0;
      hang_cnt   <= '0;
      land_pulse <= 1'b0;
    end else begin
      land_pulse <= step & land_next;
      if (step) begin
        state    <= state_next;
        y        <= y_next;
        vel      <= vel_next;
        hang_cnt <= hang_next;
      end
    end
  end

  always_comb begin
    state_next = state;
    y_next     = y;
    vel_next   = vel;
    hang_next  = hang_cnt;
    land_next  = 1'b0;
    case (state)
      ST_GROUND, ST_DUCK: begin
        if (jump_req) begin
          state_next = ST_RISE;
          vel_next   = JUMP_V_L;
        end else begin
          state_next = duck_s2 ? ST_DUCK : ST_GROUND;
        end
      end
      ST_RISE: begin
        y_next = (rise_sum > MAX_Y_X) ? MAX_Y_L : rise_sum[Y_W-1:0];
        if (vel <= GRAV_L) begin
          if (HANG_TICKS == 0) begin
            state_next = ST_FALL;
            vel_next   = GRAV_L;
          end else begin
            state_next = ST_HANG;
            vel_next   = '0;
            hang_next  = HANG_L;
          end
        end else begin
          vel_next = vel - GRAV_L;
        end
      end
      ST_HANG: begin
        if (hang_cnt <= HC_ONE) begin
          state_next = ST_FALL;
          vel_next   = GRAV_L;
        end else begin
          hang_next = hang_cnt - HC_ONE;
        end
      end
      ST_FALL: begin
        if (y <= vel) begin
          y_next     = '0;
          vel_next   = '0;
          state_next = duck_s2 ? ST_DUCK : ST_GROUND;
          land_next  = 1'b1;
        end else begin
          y_next   = y - vel;
          vel_next = (fall_sum > JUMP_V_X) ? JUMP_V_L : fall_sum[Y_W-1:0];
        end
      end
      default: state_next = ST_GROUND;
    endcase
  end

  always_comb begin
    dino_y     = y;
    dino_state = state;
    airborne   = in_air;
  end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: two parameterisations share one stimulus stream and
// are checked every cycle against a tick-level motion model plus literal anchors.
module tb_dino_jump_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_in = 1'b0, jump_btn = 1'b0, duck_btn = 1'b0, freeze = 1'b0;

  logic [7:0] y_a;
  logic [6:0] y_b;
  logic [2:0] st_a, st_b;
  logic       air_a, air_b, land_a, land_b;

  dino_jump_ctrl #(.Y_W(8), .JUMP_V(4), .GRAVITY(1), .MAX_Y(120), .HANG_TICKS(1)) dut_a (
    .clk(clk), .rst(rst), .tick_in(tick_in), .jump_btn(jump_btn), .duck_btn(duck_btn),
    .freeze(freeze), .dino_y(y_a), .dino_state(st_a), .airborne(air_a), .land_pulse(land_a));

  dino_jump_ctrl #(.Y_W(7), .JUMP_V(100), .GRAVITY(5), .MAX_Y(120), .HANG_TICKS(0)) dut_b (
    .clk(clk), .rst(rst), .tick_in(tick_in), .jump_btn(jump_btn), .duck_btn(duck_btn),
    .freeze(freeze), .dino_y(y_b), .dino_state(st_b), .airborne(air_b), .land_pulse(land_b));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int land_cnt_a = 0;
  int max_y_b = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per instance, motion expressed tick by tick in plain integers.
  int p_jv[2] = '{4, 100};
  int p_gr[2] = '{1, 5};
  int p_my[2] = '{120, 120};
  int p_ht[2] = '{1, 0};
  int m_y[2], m_vel[2], m_st[2], m_hc[2];
  bit m_land[2], m_req[2];
  bit jh[3], dh[3];
  bit tp;

  task automatic model_step(input int i, input bit tick_evt, input bit rise, input bit dsync);
    bit air, old_req;
    air     = (m_st[i] >= 2);
    old_req = m_req[i];
    m_land[i] = 1'b0;
    if (freeze || air) m_req[i] = 1'b0;
    else if (rise)     m_req[i] = 1'b1;
    else if (tick_evt) m_req[i] = 1'b0;
    if (tick_evt && !freeze) begin
      if (m_st[i] < 2) begin
        if (old_req) begin m_st[i] = 2; m_vel[i] = p_jv[i]; end
        else m_st[i] = dsync ? 1 : 0;
      end else if (m_st[i] == 2) begin
        m_y[i] = (m_y[i] + m_vel[i] > p_my[i]) ? p_my[i] : m_y[i] + m_vel[i];
        if (m_vel[i] <= p_gr[i]) begin
          if (p_ht[i] == 0) begin m_st[i] = 4; m_vel[i] = p_gr[i]; end
          else begin m_st[i] = 3; m_vel[i] = 0; m_hc[i] = p_ht[i]; end
        end else m_vel[i] -= p_gr[i];
      end else if (m_st[i] == 3) begin
        if (m_hc[i] <= 1) begin m_st[i] = 4; m_vel[i] = p_gr[i]; end
        else m_hc[i]--;
      end else begin
        if (m_y[i] <= m_vel[i]) begin
          m_y[i] = 0; m_vel[i] = 0; m_st[i] = dsync ? 1 : 0; m_land[i] = 1'b1;
        end else begin
          m_y[i] -= m_vel[i];
          m_vel[i] = (m_vel[i] + p_gr[i] > p_jv[i]) ? p_jv[i] : m_vel[i] + p_gr[i];
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_y[i] = 0; m_vel[i] = 0; m_st[i] = 0; m_hc[i] = 0; m_land[i] = 0; m_req[i] = 0;
      end
      for (int k = 0; k < 3; k++) begin jh[k] = 0; dh[k] = 0; end
      tp = 0;
    end else begin
      // jh[k]/dh[k]: button level sampled k+1 edges ago.
      for (int i = 0; i < 2; i++) model_step(i, tick_in && !tp, jh[1] && !jh[2], dh[1]);
      jh[2] = jh[1]; jh[1] = jh[0]; jh[0] = jump_btn;
      dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = duck_btn;
      tp = tick_in;
    end
  end

  always @(negedge clk) begin
    check("y_a", int'(y_a), m_y[0]);
    check("state_a", int'(st_a), m_st[0]);
    check("air_a", int'(air_a), int'(m_st[0] >= 2));
    check("land_a", int'(land_a), int'(m_land[0]));
    check("y_b", int'(y_b), m_y[1]);
    check("state_b", int'(st_b), m_st[1]);
    check("air_b", int'(air_b), int'(m_st[1] >= 2));
    check("land_b", int'(land_b), int'(m_land[1]));
    if (land_a) land_cnt_a++;
    if (int'(y_b) > max_y_b) max_y_b = int'(y_b);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    tick_in = 1'b1;
    wait_clks($urandom_range(1, 3));
    tick_in = 1'b0;
    wait_clks($urandom_range(1, 3));
  endtask

  task automatic press_jump();
    jump_btn = 1'b1;
    wait_clks($urandom_range(1, 3));
    jump_btn = 1'b0;
    wait_clks(4);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (!(m_st[0] == 0 && m_st[1] == 0) && n < 200) begin
      do_tick();
      n++;
    end
    check("settle_grounded", int'(st_a == 3'd0 && st_b == 3'd0), 1);
  endtask

  task automatic full_jump(input bool_double);
    exp_q = '{8'd0, 8'd4, 8'd7, 8'd9, 8'd10, 8'd10, 8'd9, 8'd7, 8'd4, 8'd0};
    land_cnt_a = 0;
    press_jump();
    for (int t = 0; t < 10; t++) begin
      if (bool_double && t == 4) press_jump();
      do_tick();
      check("traj_a", int'(y_a), int'(exp_q.pop_front()));
    end
    check("land_count_a", land_cnt_a, 1);
    check("end_state_a", int'(st_a), 0);
  endtask

  initial begin
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    check("reset_y", int'(y_a), 0);
    check("reset_state", int'(st_a), 0);
    check("reset_air", int'(air_a), 0);
    check("reset_land", int'(land_b), 0);
    repeat (3) do_tick();
    check("idle_state", int'(st_a), 0);

    full_jump(1'b0);
    settle();
    full_jump(1'b1);
    settle();

    duck_btn = 1'b1;
    wait_clks(4);
    do_tick();
    check("duck_enter", int'(st_a), 1);
    press_jump();
    do_tick();
    check("duck_jump", int'(st_a), 2);
    repeat (9) do_tick();
    check("duck_land", int'(st_a), 1);
    duck_btn = 1'b0;
    wait_clks(4);
    settle();

    press_jump();
    repeat (3) do_tick();
    check("pre_freeze_y", int'(y_a), 7);
    freeze = 1'b1;
    repeat (10) do_tick();
    press_jump();
    repeat (10) do_tick();
    check("freeze_y", int'(y_a), 7);
    check("freeze_state", int'(st_a), 2);
    freeze = 1'b0;
    do_tick();
    check("thaw_y", int'(y_a), 9);
    settle();
    freeze = 1'b1;
    press_jump();
    freeze = 1'b0;
    do_tick();
    check("frozen_press_discarded", int'(st_a), 0);

    press_jump();
    do_tick();
    tick_in = 1'b1;
    wait_clks(30);
    check("tick_high_one_step", int'(y_a), 4);
    tick_in = 1'b0;
    wait_clks(20);
    check("tick_fall_ignored", int'(y_a), 4);
    settle();
    check("sat_max_b", max_y_b, 120);

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      if ($urandom_range(0, 7) == 0) jump_btn = ~jump_btn;
      if ($urandom_range(0, 30) == 0) duck_btn = ~duck_btn;
      freeze = ($urandom_range(0, 9) == 0);
    end
    tick_in = 1'b0; jump_btn = 1'b0; duck_btn = 1'b0; freeze = 1'b0;
    wait_clks(4);
    settle();

    press_jump();
    repeat (3) do_tick();
    check("pre_reset_y", int'(y_a), 7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_y", int'(y_a), 0);
    check("midrst_state", int'(st_a), 0);
    check("midrst_air", int'(air_a), 0);
    check("midrst_land", int'(land_a), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_clks(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dino_jump_ctrl.md
Name: dino_jump_ctrl

Overview:
Game-tick consumer directly downstream of the clock divider. It takes the divider's slow toggling output as a level input, detects its rising edges inside the single system clock domain, and advances the T-Rex vertical-motion state machine once per tick. Its outputs are dino height, pose state and a landing pulse, which feed the sprite renderer and the collision logic.

Parameters:
Y_W, 8, width of height and velocity registers (unsigned)
JUMP_V, 12, take-off velocity in pixels/tick
GRAVITY, 1, velocity change per tick
MAX_Y, 120, height saturation ceiling
HANG_TICKS, 2, ticks spent at apex (0 = no hang)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick_in  in  1  divided-clock level from divider; each rising edge is one game tick
jump_btn  in  1  raw jump button, asynchronous
duck_btn  in  1  raw duck button, asynchronous
freeze  in  1  game-over/pause; halts all motion
dino_y  out  Y_W  height above ground, 0 = on ground
dino_state  out  3  0=GROUND 1=DUCK 2=RISE 3=HANG 4=FALL
airborne  out  1  high in RISE, HANG and FALL
land_pulse  out  1  one clk pulse on landing

Behaviour:
- Reset (async, rst=1): dino_y=0, vel=0, hang_cnt=0, state=GROUND, land_pulse=0, tick_d=0, sync flops=0, jump_req=0. Reset mid-jump returns to ground immediately.
- Synchronisers: jump_btn and duck_btn each pass through 2 flops. jump_rise = sync & ~sync_prev.
- Tick detection: tick_evt = tick_in & ~tick_d, with tick_d registered every clk. The tick is one clk wide. Falling edges are ignored.
- jump_req: set on jump_rise while state is GROUND or DUCK and freeze=0. Held until consumed on the next tick_evt. Cleared whenever airborne or freeze=1, so there is no double jump and no buffered mid-air press.
- All state/height/velocity updates occur only on clk edges where tick_evt=1 and freeze=0. Otherwise everything holds.
- GROUND: jump_req goes to RISE, vel=JUMP_V, y stays 0, jump_req cleared. Otherwise duck_sync goes to DUCK. Jump has priority over duck.
- DUCK: jump_req goes to RISE, same as from GROUND. If duck_sync=0, go to GROUND.
- RISE: y = min(y+vel, MAX_Y), computed with a carry bit before the clamp. If vel<=GRAVITY: go to HANG with vel=0 and hang_cnt=HANG_TICKS; if HANG_TICKS=0, go directly to FALL with vel=GRAVITY. Otherwise vel -= GRAVITY.
- HANG: if hang_cnt<=1, go to FALL with vel=GRAVITY. Otherwise hang_cnt -= 1. HANG lasts exactly HANG_TICKS ticks.
- FALL: if y<=vel, set y=0, vel=0, next state DUCK if duck_sync else GROUND, and land_pulse=1 for that single clk. Otherwise y -= vel and vel = min(vel+GRAVITY, JUMP_V).
- duck_btn has no effect while airborne except selecting the landing state.
- Latency: jump press to first state change is 2 sync clks plus 1 capture clk plus wait to next tick_evt. Height changes on the tick after take-off.
- freeze asserted mid-air: y, vel and state are held indefinitely. Motion resumes from the held values on the first tick_evt after freeze drops.
- tick_in stuck high or low: no ticks, no motion.
- land_pulse is 0 in every other cycle. airborne is combinational from state.

Test Plan:
- Reset then idle: rst pulse mid-run at y=7 in RISE -> immediately y=0, state=0, airborne=0, land_pulse=0.
- Full jump (JUMP_V=4, GRAVITY=1, HANG_TICKS=1): press jump, then 10 ticks. Per-tick y: take-off 0, RISE 4,7,9,10, HANG 10, FALL 9,7,4,0. Exactly one land_pulse on the final tick; state ends GROUND.
- No double jump: press jump again at y=9 -> trajectory identical to the previous scenario; jump_req stays 0.
- Duck: hold duck_btn on ground -> DUCK at next tick. Press jump while ducking -> RISE. Keep duck held through landing -> state=DUCK after landing.
- Freeze: assert freeze at y=7 for 20 ticks -> y=7 and state unchanged. A jump press during freeze is discarded. Release -> next tick continues the sequence with y=9.
- Saturation and tick edges (JUMP_V=100, MAX_Y=120): y clamps at 120, with no wrap to a small value. Only rising edges of tick_in advance motion, and tick_in held at 1 produces no motion.
